lcd_reg_monitor: RTL and testbench

LCD_REG_MONITOR -- requirements
Module: lcd_reg_monitor

---
 rtl/lcd_pkg.sv | 75 +++++++
 rtl/lcd_reg_monitor_if.sv | 11 +
 rtl/lcd_byte_writer.sv | 85 ++++++++
 rtl/lcd_reg_monitor.sv | 171 +++++++++++++++++
 tb/tb_lcd_reg_monitor.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared constants and character helpers for the HD44780 register monitor.
// Holds command bytes, FSM state encoding and the hex/line character mapping.
package lcd_pkg;

  localparam int CNT_W = 24;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_LINE1    = 8'h80;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_P     = 8'h50;
  localparam logic [7:0] CH_C     = 8'h43;
  localparam logic [7:0] CH_R     = 8'h52;
  localparam logic [7:0] CH_U     = 8'h55;
  localparam logic [7:0] CH_N     = 8'h4E;
  localparam logic [7:0] CH_E     = 8'h45;
  localparam logic [7:0] CH_D     = 8'h44;

  localparam logic [4:0] L1_LEN = 5'd11;
  localparam logic [4:0] L2_LEN = 5'd16;

  localparam logic [2:0] ST_PWR_WAIT = 3'd0;
  localparam logic [2:0] ST_INIT     = 3'd1;
  localparam logic [2:0] ST_IDLE     = 3'd2;
  localparam logic [2:0] ST_L1_ADDR  = 3'd3;
  localparam logic [2:0] ST_L1_CHARS = 3'd4;
  localparam logic [2:0] ST_L2_ADDR  = 3'd5;
  localparam logic [2:0] ST_L2_CHARS = 3'd6;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  // pos 0 selects the most significant nibble.
  function automatic logic [7:0] word_digit(input logic [31:0] word, input logic [2:0] pos);
    logic [2:0] k;
    k = 3'd7 - pos;
    return hex_char(word[{k, 2'b00} +: 4]);
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return CMD_FUNC_SET;
      2'd1:    return CMD_DISP_ON;
      2'd2:    return CMD_ENTRY;
      default: return CMD_CLEAR;
    endcase
  endfunction

  function automatic logic [7:0] line1_char(input logic [4:0] idx, input logic [31:0] pc);
    case (idx)
      5'd0:    return CH_P;
      5'd1:    return CH_C;
      5'd2:    return CH_SPACE;
      default: return word_digit(pc, 3'(idx - 5'd3));
    endcase
  endfunction

  // Trailing space pads the status word to the full 16-column line.
  function automatic logic [7:0] line2_char(input logic [4:0] idx, input logic [31:0] value,
                                            input logic fin);
    if (idx == 5'd0)  return CH_R;
    if (idx == 5'd1)  return CH_SPACE;
    if (idx <= 5'd9)  return word_digit(value, 3'(idx - 5'd2));
    if (idx == 5'd11) return fin ? CH_E : CH_R;
    if (idx == 5'd12) return fin ? CH_N : CH_U;
    if (idx == 5'd13) return fin ? CH_D : CH_N;
    return CH_SPACE;
  endfunction

endpackage

// File: rtl/lcd_reg_monitor_if.sv
// HD44780 pin bundle; the monitor drives it as master, the panel side is slave.
interface lcd_reg_monitor_if;
  logic [7:0] LCD_data;
  logic       LCD_en;
  logic       LCD_rw;
  logic       LCD_rs;
  logic       LCD_blon;

  modport master (output LCD_data, LCD_en, LCD_rw, LCD_rs, LCD_blon);
  modport slave  (input  LCD_data, LCD_en, LCD_rw, LCD_rs, LCD_blon);
endinterface

// File: rtl/lcd_byte_writer.sv
// One HD44780 byte write: setup cycle, EN_CYCLES strobe, hold cycle, then settle.
// done marks the last settle cycle so the next start can chain without a gap.
module lcd_byte_writer
  import lcd_pkg::*;
#(
    parameter int EN_CYCLES   = 25,
    parameter int WAIT_CYCLES = 2000,
    parameter int CLR_CYCLES  = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] byte_val,
    input  logic       long_wait,
    output logic       busy,
    output logic       done,
    output logic [7:0] lcd_data,
    output logic       lcd_en,
    output logic       lcd_rs
);

    localparam logic [2:0] W_IDLE   = 3'd0;
    localparam logic [2:0] W_SETUP  = 3'd1;
    localparam logic [2:0] W_STROBE = 3'd2;
    localparam logic [2:0] W_HOLD   = 3'd3;
    localparam logic [2:0] W_SETTLE = 3'd4;

    logic [2:0]       phase;
    logic [CNT_W-1:0] cnt;
    logic             long_r;
    logic             ready;

    assign done  = (phase == W_SETTLE) &&
                   (cnt == (long_r ? CNT_W'(CLR_CYCLES - 1) : CNT_W'(WAIT_CYCLES - 1)));
    assign ready = (phase == W_IDLE) || done;
    assign busy  = (phase != W_IDLE);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            phase    <= W_IDLE;
            cnt      <= '0;
            long_r   <= 1'b0;
            lcd_data <= 8'h00;
            lcd_en   <= 1'b0;
            lcd_rs   <= 1'b0;
        end else if (start && ready) begin
            phase    <= W_SETUP;
            cnt      <= '0;
            long_r   <= long_wait;
            lcd_data <= byte_val;
            lcd_rs   <= rs;
            lcd_en   <= 1'b0;
        end else begin
            case (phase)
                W_SETUP: begin
                    lcd_en <= 1'b1;
                    phase  <= W_STROBE;
                    cnt    <= '0;
                end
                W_STROBE: begin
                    if (cnt == CNT_W'(EN_CYCLES - 1)) begin
                        lcd_en <= 1'b0;
                        phase  <= W_HOLD;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                W_HOLD: begin
                    phase <= W_SETTLE;
                    cnt   <= '0;
                end
                W_SETTLE: begin
                    if (done) phase <= W_IDLE;
                    else      cnt   <= cnt + 1'b1;
                end
                default: phase <= W_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lcd_reg_monitor.sv
// Paints "PC xxxxxxxx" / "R xxxxxxxx RUN|END" on an HD44780 from snapshotted inputs.
// The FSM only chooses bytes; lcd_byte_writer owns all pin timing.
module lcd_reg_monitor
  import lcd_pkg::*;
#(
    parameter int EN_CYCLES   = 25,
    parameter int WAIT_CYCLES = 2000,
    parameter int CLR_CYCLES  = 82000,
    parameter int PWR_CYCLES  = 750000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         pc,
    input  logic [31:0]         value,
    input  logic                final_flag,  // "final" is a reserved word
    input  logic                refresh,
    output logic                busy,
    lcd_reg_monitor_if.master   lcd
);

    logic [2:0]       state;
    logic [4:0]       idx;
    logic [CNT_W-1:0] pwr_cnt;
    logic             pending;
    logic [31:0]      snap_pc, snap_value;
    logic             snap_final;

    logic       wr_start, wr_rs, wr_long, wr_busy, wr_done, wr_ready, accept;
    logic [7:0] wr_byte, wr_data;
    logic       wr_en, wr_rs_pin;

    assign wr_ready = !wr_busy || wr_done;
    assign accept   = wr_start && wr_ready;
    assign busy     = (state != ST_IDLE);

    // NOTE: every always_comb output gets a default first, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        wr_start = 1'b0;
        wr_byte  = 8'h00;
        wr_rs    = 1'b0;
        wr_long  = 1'b0;
        case (state)
            ST_PWR_WAIT: begin
                wr_start = (pwr_cnt == CNT_W'(PWR_CYCLES - 1));
                wr_byte  = CMD_FUNC_SET;
            end
            ST_INIT: begin
                wr_start = 1'b1;
                wr_byte  = init_cmd(idx[1:0]);
                wr_long  = (idx == 5'd3);
            end
            // Frame start issues the line-1 address in the same cycle refresh is seen.
            ST_IDLE: begin
                wr_start = refresh || pending;
                wr_byte  = CMD_LINE1;
            end
            ST_L1_ADDR: begin
                wr_start = 1'b1;
                wr_byte  = CMD_LINE1;
            end
            ST_L1_CHARS: begin
                wr_start = 1'b1;
                wr_rs    = 1'b1;
                wr_byte  = line1_char(idx, snap_pc);
            end
            ST_L2_ADDR: begin
                wr_start = 1'b1;
                wr_byte  = CMD_LINE2;
            end
            ST_L2_CHARS: begin
                wr_start = (idx < L2_LEN);
                wr_rs    = 1'b1;
                wr_byte  = line2_char(idx, snap_value, snap_final);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_PWR_WAIT;
            idx        <= '0;
            pwr_cnt    <= '0;
            pending    <= 1'b0;
            snap_pc    <= '0;
            snap_value <= '0;
            snap_final <= 1'b0;
        end else begin
            if (refresh && state != ST_IDLE) pending <= 1'b1;
            case (state)
                ST_PWR_WAIT: begin
                    if (accept) begin
                        state <= ST_INIT;
                        idx   <= 5'd1;
                    end else begin
                        pwr_cnt <= pwr_cnt + 1'b1;
                    end
                end
                ST_INIT: if (accept) begin
                    if (idx == 5'd3) begin
                        state      <= ST_L1_ADDR;
                        idx        <= '0;
                        snap_pc    <= pc;
                        snap_value <= value;
                        snap_final <= final_flag;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_IDLE: if (accept) begin
                    state      <= ST_L1_CHARS;
                    idx        <= '0;
                    pending    <= 1'b0;
                    snap_pc    <= pc;
                    snap_value <= value;
                    snap_final <= final_flag;
                end
                ST_L1_ADDR: if (accept) begin
                    state <= ST_L1_CHARS;
                    idx   <= '0;
                end
                ST_L1_CHARS: if (accept) begin
                    if (idx == L1_LEN - 5'd1) begin
                        state <= ST_L2_ADDR;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_L2_ADDR: if (accept) begin
                    state <= ST_L2_CHARS;
                    idx   <= '0;
                end
                ST_L2_CHARS: begin
                    if (accept) idx <= idx + 1'b1;
                    else if (idx == L2_LEN && wr_done) begin
                        state <= ST_IDLE;
                        idx   <= '0;
                    end
                end
                default: state <= ST_PWR_WAIT;
            endcase
        end
    end

    lcd_byte_writer #(
        .EN_CYCLES  (EN_CYCLES),
        .WAIT_CYCLES(WAIT_CYCLES),
        .CLR_CYCLES (CLR_CYCLES)
    ) u_writer (
        .clk      (clk),
        .rst      (rst),
        .start    (wr_start),
        .rs       (wr_rs),
        .byte_val (wr_byte),
        .long_wait(wr_long),
        .busy     (wr_busy),
        .done     (wr_done),
        .lcd_data (wr_data),
        .lcd_en   (wr_en),
        .lcd_rs   (wr_rs_pin)
    );

    assign lcd.LCD_data = wr_data;
    assign lcd.LCD_en   = wr_en;
    assign lcd.LCD_rs   = wr_rs_pin;
    assign lcd.LCD_rw   = 1'b0;
    assign lcd.LCD_blon = 1'b1;

endmodule

// File: tb/tb_lcd_reg_monitor.sv
// Self-checking bench: every LCD byte is compared against a string-level model of
// the screen contents, with literal checks on timing, reset and key frames.
module tb_lcd_reg_monitor;

  localparam int EN_P   = 2;
  localparam int WAIT_P = 4;
  localparam int CLR_P  = 8;
  localparam int PWR_P  = 10;
  localparam int SLOT   = EN_P + 2 + WAIT_P;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc = '0, value = '0;
  logic        final_flag = 1'b0, refresh = 1'b0;
  logic        busy;

  lcd_reg_monitor_if lcd_bus ();

  lcd_reg_monitor #(
      .EN_CYCLES(EN_P), .WAIT_CYCLES(WAIT_P), .CLR_CYCLES(CLR_P), .PWR_CYCLES(PWR_P)
  ) dut (
      .clk(clk), .rst(rst), .pc(pc), .value(value), .final_flag(final_flag),
      .refresh(refresh), .busy(busy), .lcd(lcd_bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [8:0] exp_q[$];   // {rs, data} expected in order
  logic [7:0] got_q[$];   // data bytes seen at each strobe rise
  int         rise_t[$];  // cycle number of each strobe rise

  localparam string HEXS = "0123456789ABCDEF";

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic string hex8(input logic [31:0] w);
    string s = "";
    for (int i = 7; i >= 0; i--) begin
      int n = int'(w[i*4 +: 4]);
      s = {s, HEXS.substr(n, n)};
    end
    return s;
  endfunction

  task automatic push_init();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h06});
    exp_q.push_back({1'b0, 8'h01});
  endtask

  task automatic push_frame(input logic [31:0] p, input logic [31:0] v, input logic f);
    string l1, l2;
    l1 = {"PC ", hex8(p)};
    l2 = {"R ", hex8(v), " ", (f ? "END" : "RUN"), "  "};
    exp_q.push_back({1'b0, 8'h80});
    for (int i = 0; i < l1.len(); i++) exp_q.push_back({1'b1, l1[i]});
    exp_q.push_back({1'b0, 8'hC0});
    for (int i = 0; i < l2.len(); i++) exp_q.push_back({1'b1, l2[i]});
  endtask

  function automatic logic [127:0] got_str(input int start, input int len);
    logic [127:0] r = '0;
    for (int i = 0; i < len; i++)
      r = {r[119:0], (start + i < got_q.size()) ? got_q[start + i] : 8'h00};
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: byte compare at each rise, pulse width and hold check at each fall.
  int         hi = 0;
  logic       en_prev = 1'b0;
  logic [8:0] cap = '0;
  always @(negedge clk) begin
    if (lcd_bus.LCD_en === 1'b1 && !en_prev) begin
      hi  <= 1;
      cap <= {lcd_bus.LCD_rs, lcd_bus.LCD_data};
      rise_t.push_back(cyc);
      got_q.push_back(lcd_bus.LCD_data);
      check("rw_blon", {lcd_bus.LCD_rw, lcd_bus.LCD_blon}, 2'b01);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_byte: got %h expected none", {lcd_bus.LCD_rs, lcd_bus.LCD_data});
      end else begin
        check("byte", {lcd_bus.LCD_rs, lcd_bus.LCD_data}, exp_q.pop_front());
      end
    end else if (lcd_bus.LCD_en === 1'b1) begin
      hi <= hi + 1;
    end else if (en_prev && rst) begin
      check("en_width", hi, EN_P);
      check("hold_data", {lcd_bus.LCD_rs, lcd_bus.LCD_data}, cap);
    end
    en_prev <= (lcd_bus.LCD_en === 1'b1);
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(exp_q.size() == 0 && busy == 1'b0) && n < budget);
    if (n >= budget) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_idle_timeout: got %0d cycles required < %0d", n, budget);
    end
  endtask

  task automatic run_frame(input logic [31:0] p, input logic [31:0] v, input logic f);
    @(posedge clk); #1;
    pc = p; value = v; final_flag = f;
    got_q.delete();
    push_frame(p, v, f);
    refresh = 1'b1;
    @(posedge clk); #1;
    refresh = 1'b0;
    wait_idle(800);
  endtask

  task automatic check_reset_pins(input string tag);
    check({tag, "_en"},   lcd_bus.LCD_en,   1'b0);
    check({tag, "_rs"},   lcd_bus.LCD_rs,   1'b0);
    check({tag, "_rw"},   lcd_bus.LCD_rw,   1'b0);
    check({tag, "_data"}, lcd_bus.LCD_data, 8'h00);
    check({tag, "_blon"}, lcd_bus.LCD_blon, 1'b1);
    check({tag, "_busy"}, busy,             1'b1);
  endtask

  initial begin
    int rel, ref_cyc, n;
    logic [31:0] rp, rv;

    // Power-on reset and first frame.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_pins("reset");
    @(posedge clk); #1;
    pc = 32'h0000001C; value = 32'hDEADBEEF; final_flag = 1'b0;
    push_init();
    push_frame(pc, value, final_flag);
    rel = cyc;
    rst = 1'b1;
    wait_idle(2000);
    check("first_rise", rise_t.size() > 0 ? rise_t[0] - rel : -1, PWR_P + 1);
    check("gap_0x38", rise_t.size() > 4 ? rise_t[1] - rise_t[0] : -1, SLOT);
    check("gap_0x0C", rise_t.size() > 4 ? rise_t[2] - rise_t[1] : -1, SLOT);
    check("gap_0x06", rise_t.size() > 4 ? rise_t[3] - rise_t[2] : -1, SLOT);
    check("gap_clear", rise_t.size() > 4 ? rise_t[4] - rise_t[3] : -1, EN_P + 2 + CLR_P);
    check("init_literal", got_str(0, 4), 32'h380C0601);
    check("line1_literal", got_str(5, 11), "PC 0000001C");
    check("line2_literal", got_str(17, 15), "R DEADBEEF RUN ");
    check("frame0_bytes", got_q.size(), 33);

    // final=1 frame with exact latency from refresh edge to end of frame.
    @(posedge clk); #1;
    pc = 32'h00400010; value = 32'h00000001; final_flag = 1'b1;
    got_q.delete();
    push_frame(pc, value, final_flag);
    refresh = 1'b1;
    ref_cyc = cyc + 1;
    @(posedge clk); #1;
    refresh = 1'b0;
    @(negedge clk);
    check("busy_after_refresh", busy, 1'b1);
    n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("frame_latency", cyc - ref_cyc, 29 * SLOT);
    check("end_literal", got_str(24, 4), "END ");
    check("frame1_drained", exp_q.size(), 0);

    // Nibble boundary digits.
    run_frame(32'h12345678, 32'h9A0F00FA, 1'b0);
    check("nibble_literal", got_str(15, 8), "9A0F00FA");

    // Three refreshes mid-frame collapse into one extra frame that shows the new pc.
    @(posedge clk); #1;
    pc = 32'h11111111; value = 32'hCAFEF00D; final_flag = 1'b0;
    got_q.delete();
    push_frame(32'h11111111, value, final_flag);
    push_frame(32'h2222ABCD, value, final_flag);
    refresh = 1'b1;
    @(posedge clk); #1;
    refresh = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    pc = 32'h2222ABCD;
    for (int k = 0; k < 3; k++) begin
      refresh = 1'b1;
      @(posedge clk); #1;
      refresh = 1'b0;
      repeat (20) @(posedge clk);
      #1;
    end
    wait_idle(1500);
    repeat (30) @(negedge clk);
    check("pending_idle", busy, 1'b0);
    check("pending_bytes", got_q.size(), 58);
    check("old_pc_shown", got_str(4, 8), "11111111");
    check("new_pc_shown", got_str(33, 8), "2222ABCD");

    // Randomized frames.
    for (int k = 0; k < 4; k++) begin
      rp = $urandom;
      rv = $urandom;
      run_frame(rp, rv, 1'($urandom_range(0, 1)));
      check("rand_frame_bytes", got_q.size(), 29);
    end

    // Reset while the strobe is high in line 1.
    @(posedge clk); #1;
    pc = $urandom; value = $urandom; final_flag = 1'b1;
    got_q.delete();
    push_frame(pc, value, final_flag);
    refresh = 1'b1;
    @(posedge clk); #1;
    refresh = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(lcd_bus.LCD_en === 1'b1 && got_q.size() >= 4) && n < 300);
    check("midbyte_found", n < 300, 1'b1);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_pins("midreset");
    exp_q.delete();
    got_q.delete();
    rise_t.delete();
    @(posedge clk); #1;
    push_init();
    push_frame(pc, value, final_flag);
    rel = cyc;
    rst = 1'b1;
    wait_idle(2000);
    check("restart_first_rise", rise_t.size() > 0 ? rise_t[0] - rel : -1, PWR_P + 1);
    check("restart_bytes", got_q.size(), 33);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
